// File: rtl/lsu_ctrl.sv
// Load/store unit controller: latches a decoded memory access, runs req/gnt/rvalid to data memory,
// steers byte lanes and formats load data; stalls the core until done, flags misaligned/timeout.
module lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [1:0]            data_type_i,
    input  logic                  data_sign_ext_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] addr_lat, wdata_lat;
    logic [1:0]            type_lat;
    logic                  we_lat, sign_lat;
    logic                  aligned, timeout;
    logic [3:0]            be_lat;
    logic [DATA_WIDTH-1:0] wdata_rep, rdata_sh, rdata_fmt;

    always_comb begin
        aligned = 1'b0;
        case (data_type_i)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_i[0];
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));

    // Lane steering and load formatting all work off the latched access.
    always_comb begin
        be_lat    = 4'b1111;
        wdata_rep = wdata_lat;
        case (type_lat)
            2'b00: begin
                be_lat    = 4'b0001 << addr_lat[1:0];
                wdata_rep = {4{wdata_lat[7:0]}};
            end
            2'b01: begin
                be_lat    = 4'b0011 << addr_lat[1:0];
                wdata_rep = {2{wdata_lat[15:0]}};
            end
            default: ;
        endcase
    end

    assign rdata_sh = mem_rdata_i >> {addr_lat[1:0], 3'b000};

    always_comb begin
        rdata_fmt = mem_rdata_i;
        case (type_lat)
            2'b00:   rdata_fmt = {{24{sign_lat & rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   rdata_fmt = {{16{sign_lat & rdata_sh[15]}}, rdata_sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            type_lat  <= 2'b00;
            we_lat    <= 1'b0;
            sign_lat  <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_IDLE)
                cnt <= '0;
            else if (state != S_IDLE)
                cnt <= cnt + 1'b1;
            if (state == S_IDLE && data_req_i && aligned) begin
                addr_lat  <= addr_i;
                wdata_lat <= wdata_i;
                type_lat  <= data_type_i;
                we_lat    <= data_we_i;
                sign_lat  <= data_sign_ext_i;
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        rdata_o     = '0;
        err_o       = 1'b0;
        case (state)
            S_IDLE: begin
                if (data_req_i) begin
                    if (aligned) begin
                        stall_o    = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        err_o = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // Abort drops the request in the same cycle so no late grant can be taken.
                if (timeout) begin
                    err_o      = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    mem_req_o   = 1'b1;
                    mem_addr_o  = {addr_lat[DATA_WIDTH-1:2], 2'b00};
                    mem_we_o    = we_lat;
                    mem_be_o    = be_lat;
                    mem_wdata_o = wdata_rep;
                    stall_o     = 1'b1;
                    if (mem_gnt_i)
                        state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timeout) begin
                    err_o      = 1'b1;
                    state_next = S_IDLE;
                end else if (mem_rvalid_i) begin
                    done_o     = 1'b1;
                    rdata_o    = we_lat ? '0 : rdata_fmt;
                    state_next = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: aligned loads/stores, lane steering, misalignment, timeout, reset mid-access.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req = 1'b0, data_we = 1'b0, data_sign_ext = 1'b0;
    logic [1:0]  data_type = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        mem_req, mem_gnt = 1'b0, mem_we, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, rdata;
    logic [3:0]  mem_be;
    logic        stall, done, err;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .data_req_i(data_req), .data_we_i(data_we), .data_type_i(data_type),
        .data_sign_ext_i(data_sign_ext), .addr_i(addr), .wdata_i(wdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .stall_o(stall), .done_o(done), .rdata_o(rdata), .err_o(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one access at the negedge, sampling outputs 1ns later each cycle.
    task automatic access(input string tag, input logic we, input logic [1:0] typ, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd, input int gnt_dly);
        @(negedge clk);
        data_req = 1'b1; data_we = we; data_type = typ; data_sign_ext = sx; addr = a; wdata = wd;
        #1 chk({tag, "_c0_stall"}, stall, 1); chk({tag, "_c0_req"}, mem_req, 0);
        @(negedge clk);
        data_req = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < gnt_dly; i++) begin
            #1 chk({tag, "_hold_req"}, mem_req, 1); chk({tag, "_hold_addr"}, mem_addr, exp_addr);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        #1 chk({tag, "_req"}, mem_req, 1); chk({tag, "_addr"}, mem_addr, exp_addr);
        chk({tag, "_be"}, mem_be, exp_be); chk({tag, "_we"}, mem_we, we);
        chk({tag, "_stall_req"}, stall, 1);
        if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 chk({tag, "_wait_req"}, mem_req, 0); chk({tag, "_wait_stall"}, stall, 1);
        chk({tag, "_wait_done"}, done, 0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = rd;
        #1 chk({tag, "_done"}, done, 1); chk({tag, "_done_stall"}, stall, 0);
        if (!we) chk({tag, "_rdata"}, rdata, exp_rd);
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1 chk({tag, "_after_done"}, done, 0); chk({tag, "_after_stall"}, stall, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 chk("rst_req", mem_req, 0); chk("rst_stall", stall, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_addr", mem_addr, 0); chk("rst_be", mem_be, 0);
        @(negedge clk); rst = 1'b0;

        access("lw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h100, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0);
        access("lb",  1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
        access("lbu", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 32'h100, 4'b1000, 32'h0, 32'h0000_0080, 1);
        access("lh",  1'b0, 2'b01, 1'b1, 32'h42,  32'h0, 32'h8001_1234, 32'h40,  4'b1100, 32'h0, 32'hFFFF_8001, 0);
        access("lhu", 1'b0, 2'b01, 1'b0, 32'h40,  32'h0, 32'h8001_9234, 32'h40,  4'b0011, 32'h0, 32'h0000_9234, 0);
        access("sh",  1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 1);
        access("sb",  1'b1, 2'b00, 1'b0, 32'h301, 32'hFFFF_FF55, 32'h0, 32'h300, 4'b0010, 32'h5555_5555, 32'h0, 0);
        access("sw",  1'b1, 2'b10, 1'b0, 32'h304, 32'hCAFE_F00D, 32'h0, 32'h304, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);

        // Misaligned word and illegal type: error pulse in IDLE, no memory traffic.
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b0; data_type = 2'b10; addr = 32'h101;
        #1 chk("mis_err", err, 1); chk("mis_stall", stall, 0); chk("mis_req", mem_req, 0);
        @(negedge clk);
        data_type = 2'b11; addr = 32'h100;
        #1 chk("ill_err", err, 1); chk("ill_stall", stall, 0); chk("ill_req", mem_req, 0);
        @(negedge clk);
        data_req = 1'b0;
        #1 chk("mis_after_err", err, 0); chk("mis_after_req", mem_req, 0);

        // Timeout: grant never comes; abort on the fifth REQ cycle (counter reaches 4).
        @(negedge clk);
        data_req = 1'b1; data_type = 2'b10; addr = 32'h400;
        @(negedge clk);
        data_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_req", mem_req, 1); chk("to_err_early", err, 0); chk("to_stall", stall, 1);
            @(negedge clk);
        end
        #1 chk("to_err", err, 1); chk("to_err_stall", stall, 0); chk("to_err_done", done, 0);
        chk("to_err_req", mem_req, 0);
        @(negedge clk);
        #1 chk("to_idle_req", mem_req, 0); chk("to_idle_err", err, 0); chk("to_idle_stall", stall, 0);

        // Reset while waiting for rvalid; the late response must be ignored.
        @(negedge clk);
        data_req = 1'b1; data_type = 2'b10; addr = 32'h500;
        @(negedge clk);
        data_req = 1'b0; mem_gnt = 1'b1;
        #1 chk("rw_req", mem_req, 1);
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b1;
        #1 chk("rw_wait_stall", stall, 1);
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        #1 chk("rw_done", done, 0); chk("rw_req_after", mem_req, 0); chk("rw_stall", stall, 0);
        chk("rw_rdata", rdata, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Controller still usable after the reset.
        access("lw2", 1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 32'h0BAD_CAFE, 32'h600, 4'b1111, 32'h0, 32'h0BAD_CAFE, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
